// File: rtl/gnt_responder_if.sv
// Request/grant bundle between requesters and the grant responder.
interface gnt_responder_if #(
  parameter int N_REQ = 4,
  parameter int LAT_W = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req;
  logic [LAT_W-1:0] lat_cfg;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             timeout;

  modport master (
    output req, lat_cfg,
    input  gnt, gnt_id, busy, timeout
  );

  modport slave (
    input  req, lat_cfg,
    output gnt, gnt_id, busy, timeout
  );
endinterface

// File: rtl/gnt_responder.sv
// Round-robin grant responder with programmable grant latency and hold limit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate when any request is present
// WAIT    | owner chosen, counting down lat_cfg cycles before grant
// GRANT   | gnt driven to owner until it drops req or hits HOLD_MAX
// RELEASE | one gnt-free cycle, last_owner updated, back to IDLE
module gnt_responder #(
  parameter int N_REQ    = 4,
  parameter int LAT_W    = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  gnt_responder_if.slave  bus
);
  localparam int ID_W   = $clog2(N_REQ);
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            state, next_state;
  logic [ID_W-1:0]   owner, owner_d;
  logic [ID_W-1:0]   last_owner, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LAT_W-1:0]  cnt, cnt_d;
  logic [HOLD_W-1:0] hold, hold_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              to_q, to_d;
  logic              armed;
  logic [ID_W-1:0]   win;
  logic              owner_req;
  logic              arb_go;

  assign owner_req = bus.req[owner];
  // armed stays low for the first edge after reset release so no arbitration happens there
  assign arb_go    = armed && (|bus.req);

  // Round-robin winner: first requester at or after last_owner+1, wrapping.
  always_comb begin
    int  idx;
    logic found;
    win   = last_owner;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_owner) + i) % N_REQ;
      if (!found && bus.req[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= ID_W'(N_REQ - 1);
      id_q       <= '0;
      cnt        <= '0;
      hold       <= '0;
      gnt_q      <= '0;
      to_q       <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= next_state;
      owner      <= owner_d;
      last_owner <= last_d;
      id_q       <= id_d;
      cnt        <= cnt_d;
      hold       <= hold_d;
      gnt_q      <= gnt_d;
      to_q       <= to_d;
      armed      <= 1'b1;
    end
  end

  // Next-state decision.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (arb_go) next_state = (bus.lat_cfg == '0) ? S_GRANT : S_WAIT;
      end
      S_WAIT: begin
        if (!owner_req)                next_state = S_IDLE;
        else if (cnt == LAT_W'(1))     next_state = S_GRANT;
      end
      S_GRANT: begin
        if (!owner_req || hold == HOLD_W'(HOLD_MAX)) next_state = S_RELEASE;
      end
      S_RELEASE: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counters and owner tracking.
  always_comb begin
    owner_d = owner;
    last_d  = last_owner;
    id_d    = id_q;
    cnt_d   = cnt;
    hold_d  = hold;
    gnt_d   = '0;
    to_d    = 1'b0;
    case (state)
      S_IDLE: begin
        hold_d = '0;
        cnt_d  = '0;
        if (arb_go) begin
          owner_d = win;
          id_d    = win;
          cnt_d   = bus.lat_cfg;
        end
      end
      S_WAIT: begin
        // an abort leaves last_owner alone so the same requester keeps priority
        if (!owner_req) cnt_d = '0;
        else            cnt_d = cnt - LAT_W'(1);
      end
      S_GRANT: begin
        // a request drop takes precedence over the hold limit: plain release, no timeout
        if (owner_req) begin
          if (hold == HOLD_W'(HOLD_MAX)) begin
            to_d = 1'b1;
          end else begin
            gnt_d  = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
            hold_d = hold + HOLD_W'(1);
          end
        end
      end
      S_RELEASE: begin
        last_d = owner;
        hold_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.timeout = to_q;
  assign bus.busy    = (state != S_IDLE);
endmodule

// File: tb/tb_gnt_responder.sv
// Directed bench for gnt_responder: latency, abort, rotation, hold limit, reset.
module tb_gnt_responder;
  localparam int N_REQ    = 4;
  localparam int LAT_W    = 4;
  localparam int HOLD_MAX = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   run;
  int   waitc;
  logic [3:0] mask;

  always #5 clk = ~clk;

  gnt_responder_if #(.N_REQ(N_REQ), .LAT_W(LAT_W)) bus ();

  gnt_responder #(.N_REQ(N_REQ), .LAT_W(LAT_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    end
  endtask

  initial begin
    bus.req     = '0;
    bus.lat_cfg = '0;
    #1 rst_n = 1'b0;
    step(2);
    chk("rst_gnt",     32'(bus.gnt),     32'h0);
    chk("rst_gnt_id",  32'(bus.gnt_id),  32'h0);
    chk("rst_busy",    32'(bus.busy),    32'h0);
    chk("rst_timeout", 32'(bus.timeout), 32'h0);

    // release reset with a request already waiting: first edge must not arbitrate
    rst_n   = 1'b1;
    bus.req = 4'b0001;
    step(1);
    chk("first_edge_busy", 32'(bus.busy), 32'h0);
    step(1);
    chk("l0_arb_busy", 32'(bus.busy),   32'h1);
    chk("l0_arb_id",   32'(bus.gnt_id), 32'h0);
    chk("l0_arb_gnt",  32'(bus.gnt),    32'h0);
    step(1);
    chk("l0_gnt_rise", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("l0_gnt_hold", 32'(bus.gnt), 32'h1);
    end
    bus.req = '0;
    step(1);
    chk("l0_drop_gnt",  32'(bus.gnt),     32'h0);
    chk("l0_drop_busy", 32'(bus.busy),    32'h1);
    chk("l0_drop_to",   32'(bus.timeout), 32'h0);
    step(1);
    chk("l0_idle_busy", 32'(bus.busy), 32'h0);

    // lat_cfg=3 for requester 1; non-owner req and lat_cfg changes mid-wait are ignored
    bus.lat_cfg = 4'd3;
    bus.req     = 4'b0010;
    step(1);
    chk("l3_arb_id",   32'(bus.gnt_id), 32'h1);
    chk("l3_arb_busy", 32'(bus.busy),   32'h1);
    chk("l3_arb_gnt",  32'(bus.gnt),    32'h0);
    bus.lat_cfg = 4'd0;
    bus.req     = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("l3_wait_gnt", 32'(bus.gnt), 32'h0);
    end
    step(1);
    chk("l3_gnt_rise", 32'(bus.gnt),    32'h2);
    chk("l3_gnt_id",   32'(bus.gnt_id), 32'h1);
    bus.req = 4'b0001;
    step(1);
    chk("l3_release_gnt", 32'(bus.gnt), 32'h0);
    bus.req = '0;
    step(1);
    chk("l3_idle_busy", 32'(bus.busy), 32'h0);

    // lat_cfg=5 for requester 2, dropped during the wait
    bus.lat_cfg = 4'd5;
    bus.req     = 4'b0100;
    step(1);
    chk("ab_arb_id",   32'(bus.gnt_id), 32'h2);
    chk("ab_arb_busy", 32'(bus.busy),   32'h1);
    for (int i = 0; i < 2; i++) begin
      step(1);
      chk("ab_wait_gnt", 32'(bus.gnt), 32'h0);
    end
    bus.req = '0;
    step(1);
    chk("ab_idle_busy", 32'(bus.busy),   32'h0);
    chk("ab_idle_gnt",  32'(bus.gnt),    32'h0);
    chk("ab_keep_id",   32'(bus.gnt_id), 32'h2);
    // last owner is still 1, so with 0 and 2 requesting, 2 wins
    bus.lat_cfg = 4'd0;
    bus.req     = 4'b0101;
    step(1);
    chk("ab_rearb_id", 32'(bus.gnt_id), 32'h2);
    step(1);
    chk("ab_rearb_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    step(2);

    // rotation under continuous requests from a fresh reset
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      mask  = 4'b0001 << (k % 4);
      waitc = 0;
      while (bus.gnt == '0 && waitc < 10) begin
        step(1);
        waitc++;
      end
      chk("rot_owner", 32'(bus.gnt),    32'(mask));
      chk("rot_id",    32'(bus.gnt_id), 32'(k % 4));
      run = 0;
      while (bus.gnt == mask && run < 20) begin
        run++;
        step(1);
      end
      chk("rot_len",     32'(run),         32'd16);
      chk("rot_gap",     32'(bus.gnt),     32'h0);
      chk("rot_timeout", 32'(bus.timeout), 32'h1);
      step(1);
      chk("rot_to_pulse", 32'(bus.timeout), 32'h0);
    end
    bus.req = '0;
    step(2);

    // grant owner 3, then assert reset asynchronously in the middle of the grant
    bus.req = 4'b1000;
    step(1);
    chk("mr_arb_id", 32'(bus.gnt_id), 32'h3);
    step(1);
    chk("mr_gnt", 32'(bus.gnt), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async_gnt",  32'(bus.gnt),     32'h0);
    chk("mr_async_busy", 32'(bus.busy),    32'h0);
    chk("mr_async_id",   32'(bus.gnt_id),  32'h0);
    chk("mr_async_to",   32'(bus.timeout), 32'h0);
    step(1);
    bus.req = 4'b1001;
    rst_n   = 1'b1;
    step(1);
    chk("mr_first_edge_busy", 32'(bus.busy), 32'h0);
    step(1);
    chk("mr_arb_id0",  32'(bus.gnt_id), 32'h0);
    chk("mr_arb_busy", 32'(bus.busy),   32'h1);
    step(1);
    chk("mr_gnt0", 32'(bus.gnt), 32'h1);

    // request drop on the same edge the hold limit is reached: no timeout
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk("hm_hold", 32'(bus.gnt), 32'h1);
    end
    bus.req = '0;
    step(1);
    chk("hm_gnt",     32'(bus.gnt),     32'h0);
    chk("hm_timeout", 32'(bus.timeout), 32'h0);
    chk("hm_busy",    32'(bus.busy),    32'h1);
    step(1);
    chk("hm_idle", 32'(bus.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
